// File: rtl/sodor_instr_gen_if.sv
// Instruction offer channel between the random instruction source and the imem response mux.
interface sodor_instr_gen_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;

  modport master (output out_valid, output instr, input out_ready);
  modport slave  (input out_valid, input instr, output out_ready);
endinterface

// File: rtl/sodor_instr_gen.sv
// Seeded LFSR-driven instruction source: NOP preamble, then I-ALU / LB / LBU words,
// with optional RAW hazard injection and a bounded instruction count.
module sodor_instr_gen #(
  parameter logic [31:0] SEED          = 32'h0000_0001,
  parameter int unsigned REG_BITS      = 5,
  parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF,
  parameter int unsigned NOP_CYCLES    = 4,
  parameter int unsigned NUM_INSTR     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  sodor_instr_gen_if.master        bus,
  output logic [31:0]              count,
  output logic                     done
);

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT   = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [4:0]  REG_MASK    = 5'((32'd1 << REG_BITS) - 32'd1);
  localparam bit          NO_PREAMBLE = (NOP_CYCLES == 0);
  localparam logic [31:0] NOP_LAST    = NO_PREAMBLE ? 32'd0 : 32'(NOP_CYCLES - 1);
  localparam bit          BOUNDED     = (NUM_INSTR != 0);
  localparam logic [31:0] INSTR_LIMIT = 32'(NUM_INSTR);

  typedef enum logic [1:0] {
    S_NOP  = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_d;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic        r_done;
  logic [31:0] r_lfsr;
  logic [4:0]  r_prev_rd;
  logic [31:0] r_nop_cnt;

  logic [31:0] w_instr_d;
  logic [31:0] w_count_d;
  logic        w_done_d;
  logic [31:0] w_lfsr_d;
  logic [4:0]  w_prev_rd_d;
  logic [31:0] w_nop_cnt_d;
  logic        w_load;

  logic        w_accept;
  logic [31:0] w_lfsr_step;
  logic [11:0] w_imm;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [2:0]  w_lf3;
  logic        w_pick;
  logic        w_hz;
  logic        w_is_alu;
  logic [11:0] w_alu_imm;
  logic [31:0] w_rand_word;
  logic        w_nop_done;
  logic        w_last;

  assign w_accept    = r_valid & bus.out_ready;
  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);

  // Candidate word derived from the next LFSR state; only committed when w_load is set.
  assign w_imm    = w_lfsr_step[11:0];
  assign w_rd     = w_lfsr_step[21:17] & REG_MASK;
  assign w_f3     = w_lfsr_step[24:22];
  assign w_pick   = w_lfsr_step[25];
  assign w_lf3    = {w_lfsr_step[26], 2'b00};
  assign w_hz     = w_lfsr_step[27];
  assign w_rs1    = ((mode == 2'd3) && w_hz) ? r_prev_rd : (w_lfsr_step[16:12] & REG_MASK);
  assign w_is_alu = (mode == 2'd0) || (mode[1] && w_pick);

  always_comb begin
    w_alu_imm = w_imm;
    if (w_f3 == 3'd1) begin
      w_alu_imm = w_imm & 12'h01F;
    end else if (w_f3 == 3'd5) begin
      w_alu_imm = w_imm & 12'h41F;
    end
  end

  assign w_rand_word = w_is_alu ? {w_alu_imm, w_rs1, w_f3, w_rd, 7'b0010011}
                                : {w_imm & LOAD_IMM_MASK, w_rs1, w_lf3, w_rd, 7'b0000011};

  // With no preamble the first word is loaded on the edge that raises out_valid.
  assign w_nop_done = NO_PREAMBLE ? !r_valid : (w_accept && (r_nop_cnt == NOP_LAST));
  assign w_last     = BOUNDED && (r_count == INSTR_LIMIT - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_NOP;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_NOP:   if (w_nop_done) w_state_d = S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_d = S_DONE;
      S_DONE:  w_state_d = S_DONE;
      default: w_state_d = S_NOP;
    endcase
  end

  always_comb begin
    w_instr_d   = r_instr;
    w_count_d   = r_count;
    w_done_d    = r_done;
    w_lfsr_d    = r_lfsr;
    w_prev_rd_d = r_prev_rd;
    w_nop_cnt_d = r_nop_cnt;
    w_load      = 1'b0;
    case (r_state)
      S_NOP: begin
        if (w_nop_done) begin
          w_load = 1'b1;
        end else if (w_accept) begin
          w_nop_cnt_d = r_nop_cnt + 32'd1;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_count_d = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
          if (w_last) begin
            w_instr_d = NOP_INSTR;
            w_done_d  = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_instr_d = NOP_INSTR;
        w_done_d  = 1'b1;
      end
      default: begin
        w_instr_d = NOP_INSTR;
      end
    endcase
    if (w_load) begin
      w_instr_d   = w_rand_word;
      w_lfsr_d    = w_lfsr_step;
      w_prev_rd_d = w_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_count   <= 32'd0;
      r_done    <= 1'b0;
      r_lfsr    <= LFSR_INIT;
      r_prev_rd <= 5'd0;
      r_nop_cnt <= 32'd0;
    end else begin
      r_valid   <= 1'b1;
      r_instr   <= w_instr_d;
      r_count   <= w_count_d;
      r_done    <= w_done_d;
      r_lfsr    <= w_lfsr_d;
      r_prev_rd <= w_prev_rd_d;
      r_nop_cnt <= w_nop_cnt_d;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.instr     = r_instr;
  assign count         = r_count;
  assign done          = r_done;

endmodule

// File: tb/tb_sodor_instr_gen.sv
// Bench for sodor_instr_gen: three parameterisations checked against a spec-level stream model.
module tb_sodor_instr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rdy_a, rdy_b, rdy_c;
  logic [1:0] md_a, md_b, md_c;
  logic [31:0] cnt_a, cnt_b, cnt_c;
  logic dn_a, dn_b, dn_c;

  sodor_instr_gen_if if_a ();
  sodor_instr_gen_if if_b ();
  sodor_instr_gen_if if_c ();

  assign if_a.out_ready = rdy_a;
  assign if_b.out_ready = rdy_b;
  assign if_c.out_ready = rdy_c;

  sodor_instr_gen #(.SEED(32'h0000_0001), .REG_BITS(5), .LOAD_IMM_MASK(12'hFFF),
                    .NOP_CYCLES(0), .NUM_INSTR(0))
    u_a (.clk(clk), .reset(rst), .mode(md_a), .bus(if_a), .count(cnt_a), .done(dn_a));

  sodor_instr_gen #(.SEED(32'hC0FF_EE11), .REG_BITS(4), .LOAD_IMM_MASK(12'hFFF),
                    .NOP_CYCLES(4), .NUM_INSTR(10))
    u_b (.clk(clk), .reset(rst), .mode(md_b), .bus(if_b), .count(cnt_b), .done(dn_b));

  sodor_instr_gen #(.SEED(32'h0000_0000), .REG_BITS(3), .LOAD_IMM_MASK(12'h03C),
                    .NOP_CYCLES(2), .NUM_INSTR(0))
    u_c (.clk(clk), .reset(rst), .mode(md_c), .bus(if_c), .count(cnt_c), .done(dn_c));

  int n_tests = 0;
  int n_fail  = 0;
  int cur;

  // Reference model state
  logic [31:0] m_seed, m_lfsr, m_exp, m_count;
  logic [4:0]  m_prev;
  logic [11:0] m_mask;
  int          m_rb, m_nop, m_nop_left;
  int unsigned m_num;
  bit          m_done;
  logic [31:0] q[$];
  logic [31:0] q_ref[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Builds the word for LFSR value l straight from the field rules.
  function automatic logic [31:0] gen(input logic [31:0] l, input int md, input logic [4:0] prev,
                                      input int rb, input logic [11:0] mask,
                                      output logic [4:0] rd_o);
    int unsigned modn = 32'd1 << rb;
    int unsigned imm  = 32'(l[11:0]);
    int unsigned rs1  = 32'(l[16:12]) % modn;
    int unsigned rd   = 32'(l[21:17]) % modn;
    int unsigned f3   = 32'(l[24:22]);
    bit alu = (md == 0) || (md >= 2 && l[25]);
    if (md == 3 && l[27]) rs1 = 32'(prev);
    rd_o = 5'(rd);
    if (alu) begin
      if (f3 == 1) imm = imm % 32;
      else if (f3 == 5) imm = (imm % 32) + (imm & 32'h400);
      return (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
    end
    return ((imm & 32'(mask)) << 20) + (rs1 << 15) + ((l[26] ? 32'd4 : 32'd0) << 12)
           + (rd << 7) + 32'h3;
  endfunction

  task automatic load_random(input int md);
    logic [31:0] l;
    logic [4:0]  rd;
    l      = step(m_lfsr);
    m_exp  = gen(l, md, m_prev, m_rb, m_mask, rd);
    m_lfsr = l;
    m_prev = rd;
  endtask

  task automatic model_reset(input int md);
    m_lfsr     = (m_seed == 32'h0) ? 32'h1 : m_seed;
    m_prev     = 5'd0;
    m_count    = 32'd0;
    m_done     = 1'b0;
    m_nop_left = m_nop;
    m_exp      = 32'h13;
    if (m_nop == 0) load_random(md);
  endtask

  task automatic model_accept(input int md);
    if (m_nop_left > 0) begin
      m_nop_left--;
      if (m_nop_left == 0) load_random(md);
    end else if (!m_done) begin
      if (m_count != 32'hFFFF_FFFF) m_count++;
      if (m_num != 0 && m_count == m_num) begin
        m_exp  = 32'h13;
        m_done = 1'b1;
      end else begin
        load_random(md);
      end
    end
  endtask

  task automatic sample(output logic v, output logic [31:0] ins, output logic [31:0] c,
                        output logic d);
    case (cur)
      0:       begin v = if_a.out_valid; ins = if_a.instr; c = cnt_a; d = dn_a; end
      1:       begin v = if_b.out_valid; ins = if_b.instr; c = cnt_b; d = dn_b; end
      default: begin v = if_c.out_valid; ins = if_c.instr; c = cnt_c; d = dn_c; end
    endcase
  endtask

  task automatic drive(input logic r, input logic [1:0] m);
    case (cur)
      0:       begin rdy_a = r; md_a = m; end
      1:       begin rdy_b = r; md_b = m; end
      default: begin rdy_c = r; md_c = m; end
    endcase
  endtask

  task automatic do_reset(input logic [1:0] md);
    logic v, d;
    logic [31:0] ins, c;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, md);
    @(negedge clk);
    sample(v, ins, c, d);
    check("rst_valid", 32'(v), 32'd0);
    check("rst_instr", ins, 32'h13);
    check("rst_count", c, 32'd0);
    check("rst_done", 32'(d), 32'd0);
    rst = 1'b0;
    drive(1'b0, md);
    model_reset(int'(md));
  endtask

  // One negedge per iteration: check the offered word, then pick this cycle's ready/mode.
  task automatic run(input int n, input int ready_pct, input int mode_sel);
    logic v, d, r;
    logic [31:0] ins, c;
    logic [1:0] m;
    bit rnd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(v, ins, c, d);
      check("valid", 32'(v), 32'd1);
      check("instr", ins, m_exp);
      check("count", c, m_count);
      check("done", 32'(d), 32'(m_done));
      if (cur == 0 && ins[6:0] == 7'h13 && ins[14:12] == 3'd1)
        check("alu_slli_imm", 32'(ins[31:25]), 32'd0);
      if (cur == 0 && ins[6:0] == 7'h13 && ins[14:12] == 3'd5)
        check("alu_sri_imm", 32'(ins[31:20] & 12'hBE0), 32'd0);
      if (cur == 2 && ins != 32'h13) begin
        check("ld_opcode", 32'(ins[6:0]), 32'h03);
        check("ld_f3", 32'(ins[14:12] & 3'b011), 32'd0);
        check("ld_imm", 32'(ins[31:20] & 12'hFC3), 32'd0);
        check("ld_regs", 32'({ins[19:18], ins[11:10]}), 32'd0);
      end
      r = ($urandom_range(99) < 32'(ready_pct));
      m = (mode_sel < 0) ? 2'($urandom_range(3)) : 2'(mode_sel);
      drive(r, m);
      rnd = (m_nop_left == 0) && !m_done;
      if (r) begin
        if (rnd) q.push_back(ins);
        model_accept(int'(m));
      end
    end
  endtask

  initial begin
    logic v, d;
    logic [31:0] ins, c;
    int guard;
    rst = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    md_a = 2'd0;  md_b = 2'd0;  md_c = 2'd0;
    repeat (2) @(posedge clk);

    // DUT A: no preamble, unbounded, SEED=1
    cur = 0; m_seed = 32'h1; m_rb = 5; m_mask = 12'hFFF; m_nop = 0; m_num = 0;
    do_reset(2'd0);
    @(negedge clk);
    sample(v, ins, c, d);
    check("a_first_word", ins, 32'h0030_0813);
    check("a_first_valid", 32'(v), 32'd1);
    check("a_first_count", c, 32'd0);
    drive(1'b1, 2'd0);
    model_accept(0);
    run(300, 50, -1);
    run(200, 70, 3);

    // Same stream regardless of back-pressure
    do_reset(2'd2);
    q.delete();
    run(60, 100, 2);
    q_ref = q;
    do_reset(2'd2);
    q.delete();
    guard = 0;
    while (q.size() < q_ref.size() && guard < 600) begin
      run(1, 40, 2);
      guard++;
    end
    check("a_stream_len", 32'(q.size()), 32'(q_ref.size()));
    for (int i = 0; i < q_ref.size() && i < q.size(); i++)
      check("a_stream_word", q[i], q_ref[i]);

    // DUT B: 4-NOP preamble, bounded to 10 instructions
    cur = 1; m_seed = 32'hC0FF_EE11; m_rb = 4; m_mask = 12'hFFF; m_nop = 4; m_num = 10;
    do_reset(2'd2);
    q.delete();
    run(25, 100, 2);
    @(negedge clk);
    sample(v, ins, c, d);
    check("b_final_count", c, 32'd10);
    check("b_done", 32'(d), 32'd1);
    check("b_instr_nop", ins, 32'h13);
    check("b_words", 32'(q.size()), 32'd10);
    q_ref = q;
    drive(1'b1, 2'd2);
    do_reset(2'd2);
    q.delete();
    run(80, 50, 2);
    check("b_restart_len", 32'(q.size()), 32'd10);
    for (int i = 0; i < q_ref.size() && i < q.size(); i++)
      check("b_restart_word", q[i], q_ref[i]);

    // DUT C: loads only, narrow register window, masked immediates, SEED=0
    cur = 2; m_seed = 32'h0; m_rb = 3; m_mask = 12'h03C; m_nop = 2; m_num = 0;
    do_reset(2'd1);
    run(300, 60, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
